// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the 32x32 DataMem.
// Handles lane extract/extend on loads and read-modify-write sub-word stores.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              bad;
    logic              word_st;
    logic [4:0]        sh_amt;
    logic [DATA_W-1:0] sh_data;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;

    assign bad = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (|req_addr[1:0]));
    assign word_st = we_q & (size_q == 2'b10);
    assign sh_amt  = {lane_q, 3'b000};
    assign sh_data = mem_dataout >> sh_amt;

    always_comb begin
        ld_val = mem_dataout;
        mask   = '1;
        ins    = wdata_q;
        unique case (size_q)
            2'b00: begin
                ld_val = uns_q ? {24'b0, sh_data[7:0]}
                               : {{24{sh_data[7]}}, sh_data[7:0]};
                mask   = 32'h0000_00FF << sh_amt;
                ins    = (wdata_q & 32'h0000_00FF) << sh_amt;
            end
            2'b01: begin
                ld_val = uns_q ? {16'b0, sh_data[15:0]}
                               : {{16{sh_data[15]}}, sh_data[15:0]};
                mask   = 32'h0000_FFFF << sh_amt;
                ins    = (wdata_q & 32'h0000_FFFF) << sh_amt;
            end
            default: begin
                ld_val = mem_dataout;
                mask   = '1;
                ins    = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = bad ? RESP : ACCESS;
            ACCESS:  state_d = (we_q && !word_st) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields and response data only move at the IDLE accept edge,
    // the ACCESS read cycle and the RESP handshake.
    always_comb begin
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = bad;
                    if (!bad) mem_addr_d = req_addr[ADDR_W-1:2];
                end
            end
            ACCESS: begin
                if (!we_q) rdata_d = ld_val;
                else merge_d = (mem_dataout & ~mask) | (ins & mask);
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
        mem_addr   = mem_addr_q;
        mem_we     = 1'b0;
        mem_datain = '0;
        if (state_q == ACCESS && word_st) begin
            mem_we     = 1'b1;
            mem_datain = wdata_q;
        end else if (state_q == WRITE) begin
            mem_we     = 1'b1;
            mem_datain = merge_q;
        end
    end
endmodule
